// File: rtl/noc_local_ni.sv
// rtl/noc_local_ni.sv - Router Local-port network interface (TX packetizer, RX depacketizer)
// Optional build macro: PARITY_CHECK_EN enables RX parity checking on pe_rx_err.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   cur_addr              own node address (header src field)
//   pe_tx_start/dst/len   packet request from PE; pe_tx_start_ready high in TX idle
//   pe_tx_valid/data      payload words from PE; pe_tx_ready accepts them
//   noc_tx_data/rts       flit and strobe to router L_RX/L_DRTS; noc_tx_cts = L_CTS
//   noc_rx_data/drts      flit and strobe from router L_TX/L_RTS; noc_rx_dcts = L_DCTS
//   pe_rx_valid/ready     payload words to PE with data, sop, eop, src, err
module noc_local_ni #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  pe_tx_start,
  input  logic [AXIS-1:0]       pe_tx_dst,
  input  logic [11:0]           pe_tx_len,
  output logic                  pe_tx_start_ready,
  input  logic                  pe_tx_valid,
  input  logic [DATA_WIDTH-5:0] pe_tx_data,
  output logic                  pe_tx_ready,
  output logic [DATA_WIDTH-1:0] noc_tx_data,
  output logic                  noc_tx_rts,
  input  logic                  noc_tx_cts,
  input  logic [DATA_WIDTH-1:0] noc_rx_data,
  input  logic                  noc_rx_drts,
  output logic                  noc_rx_dcts,
  output logic                  pe_rx_valid,
  input  logic                  pe_rx_ready,
  output logic [DATA_WIDTH-5:0] pe_rx_data,
  output logic                  pe_rx_sop,
  output logic                  pe_rx_eop,
  output logic [AXIS-1:0]       pe_rx_src,
  output logic                  pe_rx_err
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(RX_DEPTH);
  localparam logic [AW:0] DCTS_MAX = DEPTH_C - (AW+1)'(2);

  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_e;

  // Bit 0 makes the whole flit even parity.
  function automatic logic [DATA_WIDTH-1:0] add_par(input logic [DATA_WIDTH-1:1] f);
    return {f, ^f};
  endfunction

  // ---------------- TX ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic                  stage_valid_q, stage_valid_d;
  logic [DATA_WIDTH-1:0] stage_flit_q, stage_flit_d;
  logic [11:0]           rem_q, rem_d;
  logic [7:0]            seq_q, seq_d;
  logic                  word_acc;

  assign noc_tx_data       = stage_flit_q;
  assign noc_tx_rts        = stage_valid_q & noc_tx_cts;
  assign pe_tx_start_ready = (tx_state_q == TX_IDLE);
  // Accepting in HEAD lets the first body word replace the header as it issues.
  assign pe_tx_ready = (tx_state_q != TX_IDLE) && (rem_q != 12'd0) && (!stage_valid_q || noc_tx_rts);
  assign word_acc    = pe_tx_valid & pe_tx_ready;

  always_comb begin
    tx_state_d    = tx_state_q;
    stage_valid_d = stage_valid_q;
    stage_flit_d  = stage_flit_q;
    rem_d         = rem_q;
    seq_d         = seq_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (pe_tx_start && pe_tx_len != 12'd0) begin
          stage_valid_d = 1'b1;
          stage_flit_d  = add_par({3'b001, pe_tx_len + 12'd1, pe_tx_dst, cur_addr, seq_q});
          rem_d         = pe_tx_len;
          seq_d         = seq_q + 8'd1;
          tx_state_d    = TX_HEAD;
        end
      end
      TX_HEAD: if (noc_tx_rts) tx_state_d = TX_BODY;
      TX_BODY: if (noc_tx_rts && rem_q == 12'd0) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (word_acc) begin
      stage_valid_d = 1'b1;
      stage_flit_d  = add_par({(rem_q == 12'd1) ? 3'b100 : 3'b010, pe_tx_data});
      rem_d         = rem_q - 12'd1;
    end else if (noc_tx_rts) begin
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q    <= TX_IDLE;
      stage_valid_q <= 1'b0;
      stage_flit_q  <= '0;
      rem_q         <= '0;
      seq_q         <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      stage_valid_q <= stage_valid_d;
      stage_flit_q  <= stage_flit_d;
      rem_q         <= rem_d;
      seq_q         <= seq_d;
    end
  end

  // ---------------- RX ----------------
  logic [DATA_WIDTH-1:0] mem_q [RX_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RX_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  dcts_q, dcts_d;
  logic [AXIS-1:0]       src_q, src_d;
  logic                  sop_q, sop_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  nempty, push, pop, is_hdr, is_data, is_tail;

  assign head    = mem_q[rd_ptr_q];
  assign nempty  = (count_q != '0);
  assign push    = noc_rx_drts && (count_q != DEPTH_C);
  assign is_hdr  = (head[31:29] == 3'b001);
  assign is_tail = (head[31:29] == 3'b100);
  assign is_data = is_tail || (head[31:29] == 3'b010);
  // Headers and unknown ids leave without PE involvement.
  assign pop     = nempty && (!is_data || pe_rx_ready);

  assign pe_rx_valid = nempty & is_data;
  assign pe_rx_data  = pe_rx_valid ? head[DATA_WIDTH-4:1] : '0;
  assign pe_rx_sop   = pe_rx_valid & sop_q;
  assign pe_rx_eop   = pe_rx_valid & is_tail;
  assign pe_rx_src   = src_q;
  assign noc_rx_dcts = dcts_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    src_d    = src_q;
    sop_d    = sop_q;
    if (push) begin
      mem_d[wr_ptr_q] = noc_rx_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (is_hdr) begin
        src_d = head[12:9];
        sop_d = 1'b1;
      end else if (is_data) begin
        sop_d = 1'b0;
      end
    end
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // Two free slots absorb a flit already in flight from the router.
    dcts_d  = (count_d <= DCTS_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dcts_q   <= 1'b0;
      src_q    <= '0;
      sop_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dcts_q   <= dcts_d;
      src_q    <= src_d;
      sop_q    <= sop_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_bad;
  logic hdr_err_q, hdr_err_d;

  assign par_bad   = ^head;
  // A bad header is reported on the packet's first payload word.
  assign pe_rx_err = pe_rx_valid & (par_bad | (sop_q & hdr_err_q));

  always_comb begin
    hdr_err_d = hdr_err_q;
    if (pop && is_hdr)       hdr_err_d = par_bad;
    else if (pop && is_data) hdr_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hdr_err_q <= 1'b0;
    else      hdr_err_q <= hdr_err_d;
  end
`else
  logic rx_par_unused;
  assign rx_par_unused = head[0];
  assign pe_rx_err     = 1'b0;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// tb/tb_noc_local_ni.sv - Directed self-checking bench for noc_local_ni
module tb_noc_local_ni;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cur_addr, pe_tx_dst, pe_rx_src;
  logic        pe_tx_start, pe_tx_start_ready, pe_tx_valid, pe_tx_ready;
  logic [11:0] pe_tx_len;
  logic [27:0] pe_tx_data, pe_rx_data;
  logic [31:0] noc_tx_data, noc_rx_data;
  logic        noc_tx_rts, noc_tx_cts, noc_rx_drts, noc_rx_dcts;
  logic        pe_rx_valid, pe_rx_ready, pe_rx_sop, pe_rx_eop, pe_rx_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        err;
    logic [3:0]  src;
    logic [27:0] data;
  } rx_t;

  logic [31:0] tx_q[$];
  int          tx_t[$];
  rx_t         rx_q[$];

  noc_local_ni dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .pe_tx_start(pe_tx_start), .pe_tx_dst(pe_tx_dst), .pe_tx_len(pe_tx_len),
    .pe_tx_start_ready(pe_tx_start_ready), .pe_tx_valid(pe_tx_valid),
    .pe_tx_data(pe_tx_data), .pe_tx_ready(pe_tx_ready),
    .noc_tx_data(noc_tx_data), .noc_tx_rts(noc_tx_rts), .noc_tx_cts(noc_tx_cts),
    .noc_rx_data(noc_rx_data), .noc_rx_drts(noc_rx_drts), .noc_rx_dcts(noc_rx_dcts),
    .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_data(pe_rx_data),
    .pe_rx_sop(pe_rx_sop), .pe_rx_eop(pe_rx_eop), .pe_rx_src(pe_rx_src),
    .pe_rx_err(pe_rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && noc_tx_rts) begin
      tx_q.push_back(noc_tx_data);
      tx_t.push_back(cyc);
    end
    if (rst && pe_rx_valid && pe_rx_ready)
      rx_q.push_back({pe_rx_sop, pe_rx_eop, pe_rx_err, pe_rx_src, pe_rx_data});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] txf(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 32'hdead_beef;
  endfunction

  function automatic int txc(input int i);
    if (i < tx_t.size()) return tx_t[i];
    return -100;
  endfunction

  function automatic rx_t rxf(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return '1;
  endfunction

  task automatic start_pkt(input logic [3:0] dst, input logic [11:0] len);
    int n = 0;
    while (!pe_tx_start_ready && n < 50) begin tick(); n++; end
    chk("start_ready_wait", {31'd0, pe_tx_start_ready}, 32'd1);
    pe_tx_start = 1'b1;
    pe_tx_dst   = dst;
    pe_tx_len   = len;
    tick();
    pe_tx_start = 1'b0;
  endtask

  task automatic push_word(input logic [27:0] w);
    int n = 0;
    pe_tx_valid = 1'b1;
    pe_tx_data  = w;
    #1;
    while (!pe_tx_ready && n < 50) begin tick(); n++; end
    chk("tx_ready_wait", {31'd0, pe_tx_ready}, 32'd1);
    tick();
    pe_tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!pe_tx_start_ready && n < 50) begin tick(); n++; end
    chk("tx_idle_wait", {31'd0, pe_tx_start_ready}, 32'd1);
  endtask

  task automatic inject(input logic [31:0] f);
    noc_rx_drts = 1'b1;
    noc_rx_data = f;
    tick();
    noc_rx_drts = 1'b0;
  endtask

  function automatic logic [31:0] body(input logic [27:0] w);
    return {3'b010, w, ^{3'b010, w}};
  endfunction

  initial begin
    rst = 1'b0; cur_addr = 4'd5; pe_tx_start = 0; pe_tx_dst = 0; pe_tx_len = 0;
    pe_tx_valid = 0; pe_tx_data = 0; noc_tx_cts = 1; noc_rx_data = 0; noc_rx_drts = 0;
    pe_rx_ready = 1;

    // Reset values
    repeat (3) tick();
    chk("rst_start_ready", {31'd0, pe_tx_start_ready}, 32'd1);
    chk("rst_tx_rts", {31'd0, noc_tx_rts}, 32'd0);
    chk("rst_tx_data", noc_tx_data, 32'd0);
    chk("rst_rx_valid", {31'd0, pe_rx_valid}, 32'd0);
    chk("rst_dcts", {31'd0, noc_rx_dcts}, 32'd0);
    rst = 1'b1;
    #1;
    chk("dcts_before_edge", {31'd0, noc_rx_dcts}, 32'd0);
    tick();
    chk("dcts_after_edge", {31'd0, noc_rx_dcts}, 32'd1);

    // Packet 0: dst A, three words, full rate
    tx_q.delete(); tx_t.delete();
    start_pkt(4'hA, 12'd3);
    chk("busy_start_ready", {31'd0, pe_tx_start_ready}, 32'd0);
    push_word(28'd1); push_word(28'd2); push_word(28'd3);
    wait_idle();
    chk("p0_count", tx_q.size(), 32'd4);
    chk("p0_head", txf(0), 32'h2009_4A00);
    chk("p0_body1", txf(1), 32'h4000_0002);
    chk("p0_body2", txf(2), 32'h4000_0004);
    chk("p0_tail", txf(3), 32'h8000_0007);
    chk("p0_back_to_back", txc(3) - txc(0), 32'd3);

    // Packet 1: seq advances to 1
    tx_q.delete(); tx_t.delete();
    start_pkt(4'hA, 12'd3);
    push_word(28'd1); push_word(28'd2); push_word(28'd3);
    wait_idle();
    chk("p1_count", tx_q.size(), 32'd4);
    chk("p1_head_seq1", txf(0), 32'h2009_4A03);

    // Packet 2: CTS low for three clocks after the header issues
    tx_q.delete(); tx_t.delete();
    start_pkt(4'hA, 12'd3);
    pe_tx_valid = 1'b1; pe_tx_data = 28'd1;
    tick();
    noc_tx_cts = 1'b0; pe_tx_data = 28'd2;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("cts0_rts", {31'd0, noc_tx_rts}, 32'd0);
      chk("cts0_data_held", noc_tx_data, 32'h4000_0002);
      chk("cts0_pe_ready", {31'd0, pe_tx_ready}, 32'd0);
      tick();
    end
    noc_tx_cts = 1'b1;
    push_word(28'd2); push_word(28'd3);
    wait_idle();
    chk("p2_count", tx_q.size(), 32'd4);
    chk("p2_head", txf(0), 32'h2009_4A05);
    chk("p2_body1", txf(1), 32'h4000_0002);
    chk("p2_body2", txf(2), 32'h4000_0004);
    chk("p2_tail", txf(3), 32'h8000_0007);

    // len == 0: no flit, seq unchanged
    tx_q.delete(); tx_t.delete();
    start_pkt(4'hA, 12'd0);
    repeat (4) tick();
    chk("len0_no_flit", tx_q.size(), 32'd0);
    chk("len0_idle", {31'd0, pe_tx_start_ready}, 32'd1);
    start_pkt(4'hA, 12'd1);
    push_word(28'd7);
    wait_idle();
    chk("p3_count", tx_q.size(), 32'd2);
    chk("p3_head_seq3", txf(0), 32'h2005_4A06);
    chk("p3_tail", txf(1), 32'h8000_000E);

    // RX: header, body, tail
    rx_q.delete();
    inject(32'h2005_4600); inject(32'h4000_0002); inject(32'h8000_0004);
    repeat (4) tick();
    chk("rx_count", rx_q.size(), 32'd2);
    chk("rx_w0_data", {4'd0, rxf(0).data}, 32'd1);
    chk("rx_w0_sop", {31'd0, rxf(0).sop}, 32'd1);
    chk("rx_w0_eop", {31'd0, rxf(0).eop}, 32'd0);
    chk("rx_w0_src", {28'd0, rxf(0).src}, 32'd3);
    chk("rx_w1_data", {4'd0, rxf(1).data}, 32'd2);
    chk("rx_w1_sop", {31'd0, rxf(1).sop}, 32'd0);
    chk("rx_w1_eop", {31'd0, rxf(1).eop}, 32'd1);

    // RX backpressure: fill while dcts allows, plus one in-flight flit
    rx_q.delete();
    pe_rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fill_dcts_open", {31'd0, noc_rx_dcts}, 32'd1);
      inject(body(28'(10 + i)));
    end
    chk("fill_dcts_closed", {31'd0, noc_rx_dcts}, 32'd0);
    inject(body(28'd13));
    chk("fill_head_valid", {31'd0, pe_rx_valid}, 32'd1);
    chk("fill_head_data", {4'd0, pe_rx_data}, 32'd10);
    pe_rx_ready = 1'b1;
    repeat (6) tick();
    chk("drain_count", rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("drain_order", {4'd0, rxf(i).data}, 32'(10 + i));
    chk("drain_dcts", {31'd0, noc_rx_dcts}, 32'd1);

    // RX parity: corrupted body word
    rx_q.delete();
    inject(32'h2005_4600); inject(32'h4000_0022); inject(32'h8000_0004);
    repeat (4) tick();
    chk("par_count", rx_q.size(), 32'd2);
    chk("par_bad_data", {4'd0, rxf(0).data}, 32'h11);
`ifdef PARITY_CHECK_EN
    chk("par_bad_err", {31'd0, rxf(0).err}, 32'd1);
`else
    chk("par_bad_err", {31'd0, rxf(0).err}, 32'd0);
`endif
    chk("par_good_err", {31'd0, rxf(1).err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
